alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - Registered 8-bit ALU: add with carry, subtract with borrow, multiply (low half), bitwise AND.
// - Sits in the datapath between operand registers and the writeback mux.
// - One result per accepted operation, fixed latency of 1 cycle.
// PARAMETERS
// - WIDTH  8  operand/result width in bits (legal: 2..32)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      synchronous reset, active-low
// - A          in   WIDTH  operand A
// - B          in   WIDTH  operand B
// - c          in   1      carry-in (add) / borrow-in (sub); ignored by mul and and
// - sel        in   2      opcode: 00 add, 01 sub, 10 mul, 11 and
// - in_valid   in   1      operands/opcode valid this cycle
// - O          out  WIDTH  registered result
// - flag       out  1      registered carry/borrow/overflow flag
// - out_valid  out  1      O/flag hold a new result this cycle
// - zero       out  1      only when ALU_ZERO_FLAG_EN defined: O == 0
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): O=0, flag=0, out_valid=0, zero=1; reset overrides in_valid.
// - Latency: in_valid=1 at edge N -> O/flag/out_valid=1 visible after edge N (one cycle).
// - in_valid=0 at an edge: out_valid=0; O and flag hold their previous values.
// - No backpressure; a new operation may be accepted every cycle.
// - sel=00: {flag,O} = A + B + c, computed at WIDTH+1 bits; flag = carry-out.
// - sel=01: O = (A - B - c) mod 2^WIDTH; flag = borrow = 1 when A < B + c (unsigned).
// - sel=10: P = A*B at 2*WIDTH bits; O = P[WIDTH-1:0]; flag = |P[2*WIDTH-1:WIDTH].
// - sel=11: O = A & B; flag = 0.
// - All arithmetic is unsigned; no signed-overflow detection.
// - Wrap-around: add FF+01+0 -> O=00, flag=1; sub 00-01-0 -> O=FF, flag=1.
// - Multiply is combinational within the one cycle; it is not pipelined.
// - sel and c are sampled only when in_valid=1; changes while in_valid=0 have no effect.
// - Reset asserted mid-stream discards the pending result; out_valid=0 on the next cycle.
// CONFIGURATION
// - Macro ALU_ZERO_FLAG_EN
// - Defined: adds port zero, registered alongside O; zero = (next O == 0).
//   - Updates only when O updates; reset value 1.
// - Undefined: port zero is absent; all other behaviour is identical.
// TESTING
// - Reset: rst_n=0 for 2 cycles -> O=00, flag=0, out_valid=0; held with in_valid=1.
// - A=01, B=01, c=0, pipelined one op per cycle, sel=00 then 01 then 10:
//   - add -> O=02 f=0
//   - sub -> O=00 f=0
//   - mul -> O=01 f=0
//   - each appears one cycle after issue
// - A=FF, B=FF, sel=10 -> O=01, flag=1 (product FE01); sel=00, c=1 -> O=FF, flag=1.
// - A=55, B=AA, c=0:
//   - sel=00 -> O=FF f=0
//   - sel=01 -> O=AB f=1
//   - sel=10 (B=FF) -> O=AB f=1
//   - sel=11 -> O=00 f=0
// - in_valid=0 after a result -> out_valid=0, O/flag hold; rst_n=0 mid-stream -> result dropped.
// - With ALU_ZERO_FLAG_EN defined: A=01, B=01, sel=01 -> zero=1; A=01, B=01, sel=00 -> zero=0.

Source files
------------

// File: rtl/alu.sv
// Registered WIDTH-bit ALU: add/sub with carry/borrow, low-half multiply, AND.
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero port (O == 0).
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] O,
    output logic             flag,
`ifdef ALU_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_b_ext;
    logic [WIDTH:0]     w_c_ext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res;
    logic               w_flag;

    logic [WIDTH-1:0]   r_o;
    logic               r_flag;
    logic               r_valid;
`ifdef ALU_ZERO_FLAG_EN
    logic               r_zero;
`endif

    assign w_a_ext = {1'b0, A};
    assign w_b_ext = {1'b0, B};
    assign w_c_ext = {{WIDTH{1'b0}}, c};
    assign w_sum   = w_a_ext + w_b_ext + w_c_ext;
    // Negative difference sets the extra top bit: that is the borrow.
    assign w_diff  = w_a_ext - w_b_ext - w_c_ext;
    assign w_prod  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    always_comb begin
        w_res  = '0;
        w_flag = 1'b0;
        unique case (sel)
            2'b00: begin
                w_res  = w_sum[WIDTH-1:0];
                w_flag = w_sum[WIDTH];
            end
            2'b01: begin
                w_res  = w_diff[WIDTH-1:0];
                w_flag = w_diff[WIDTH];
            end
            2'b10: begin
                w_res  = w_prod[WIDTH-1:0];
                w_flag = |w_prod[2*WIDTH-1:WIDTH];
            end
            2'b11: begin
                w_res  = A & B;
                w_flag = 1'b0;
            end
            default: begin
                w_res  = '0;
                w_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_o     <= '0;
            r_flag  <= 1'b0;
            r_valid <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            r_zero  <= 1'b1;
`endif
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_o    <= w_res;
                r_flag <= w_flag;
`ifdef ALU_ZERO_FLAG_EN
                r_zero <= (w_res == '0);
`endif
            end
        end
    end

    assign O         = r_o;
    assign flag      = r_flag;
    assign out_valid = r_valid;
`ifdef ALU_ZERO_FLAG_EN
    assign zero      = r_zero;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=8).
// Zero-flag checks are compiled in only when ALU_ZERO_FLAG_EN is defined.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       c;
    logic [1:0] sel;
    logic       in_valid;
    logic [7:0] O;
    logic       flag;
    logic       out_valid;
`ifdef ALU_ZERO_FLAG_EN
    logic       zero;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .c         (c),
        .sel       (sel),
        .in_valid  (in_valid),
        .O         (O),
        .flag      (flag),
`ifdef ALU_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic cc, input logic [1:0] s,
                         input logic v);
        A        = a;
        B        = b;
        c        = cc;
        sel      = s;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] o,
                              input logic f);
        check({tag, ".O"}, {24'd0, O}, {24'd0, o});
        check({tag, ".flag"}, {31'd0, flag}, {31'd0, f});
        check({tag, ".ov"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(8'h12, 8'h34, 1'b1, 2'b00, 1'b1);
        drive(8'h12, 8'h34, 1'b1, 2'b00, 1'b1);
        check("rst.O", {24'd0, O}, 32'h0);
        check("rst.flag", {31'd0, flag}, 32'd0);
        check("rst.ov", {31'd0, out_valid}, 32'd0);
`ifdef ALU_ZERO_FLAG_EN
        check("rst.zero", {31'd0, zero}, 32'd1);
`endif
        rst_n = 1'b1;

        // Back-to-back ops, each visible one cycle after issue
        drive(8'h01, 8'h01, 1'b0, 2'b00, 1'b1);
        expect_res("p_add", 8'h02, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
        check("p_add.zero", {31'd0, zero}, 32'd0);
`endif
        drive(8'h01, 8'h01, 1'b0, 2'b01, 1'b1);
        expect_res("p_sub", 8'h00, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
        check("p_sub.zero", {31'd0, zero}, 32'd1);
`endif
        drive(8'h01, 8'h01, 1'b0, 2'b10, 1'b1);
        expect_res("p_mul", 8'h01, 1'b0);

        drive(8'hFF, 8'hFF, 1'b0, 2'b10, 1'b1);
        expect_res("mul_ff", 8'h01, 1'b1);
        drive(8'hFF, 8'hFF, 1'b1, 2'b00, 1'b1);
        expect_res("add_ffc", 8'hFF, 1'b1);
        drive(8'hFF, 8'h01, 1'b0, 2'b00, 1'b1);
        expect_res("add_wrap", 8'h00, 1'b1);
        drive(8'h00, 8'h01, 1'b0, 2'b01, 1'b1);
        expect_res("sub_wrap", 8'hFF, 1'b1);

        drive(8'h55, 8'hAA, 1'b0, 2'b00, 1'b1);
        expect_res("add_55", 8'hFF, 1'b0);
        drive(8'h55, 8'hAA, 1'b0, 2'b01, 1'b1);
        expect_res("sub_55", 8'hAB, 1'b1);
        drive(8'h55, 8'hFF, 1'b0, 2'b10, 1'b1);
        expect_res("mul_55", 8'hAB, 1'b1);
        drive(8'h55, 8'hAA, 1'b0, 2'b11, 1'b1);
        expect_res("and_55", 8'h00, 1'b0);
        drive(8'h0F, 8'h3C, 1'b1, 2'b11, 1'b1);
        expect_res("and_c", 8'h0C, 1'b0);
        drive(8'h05, 8'h03, 1'b1, 2'b01, 1'b1);
        expect_res("sub_b", 8'h01, 1'b0);
        drive(8'h03, 8'h03, 1'b1, 2'b01, 1'b1);
        expect_res("sub_bb", 8'hFF, 1'b1);
        drive(8'h10, 8'h11, 1'b1, 2'b10, 1'b1);
        expect_res("mul_c", 8'h10, 1'b1);

        // Idle cycles with changing inputs must not disturb O/flag
        drive(8'h00, 8'h00, 1'b0, 2'b11, 1'b0);
        check("idle.ov", {31'd0, out_valid}, 32'd0);
        check("idle.O", {24'd0, O}, 32'h10);
        check("idle.flag", {31'd0, flag}, 32'd1);
        drive(8'h01, 8'h02, 1'b1, 2'b00, 1'b0);
        check("idle2.O", {24'd0, O}, 32'h10);
        check("idle2.flag", {31'd0, flag}, 32'd1);

        // Reset mid-stream drops the result being captured
        drive(8'h20, 8'h22, 1'b0, 2'b00, 1'b1);
        expect_res("pre_rst", 8'h42, 1'b0);
        rst_n = 1'b0;
        drive(8'h07, 8'h07, 1'b0, 2'b00, 1'b1);
        check("mrst.ov", {31'd0, out_valid}, 32'd0);
        check("mrst.O", {24'd0, O}, 32'h0);
        check("mrst.flag", {31'd0, flag}, 32'd0);
        rst_n = 1'b1;
        drive(8'h07, 8'h07, 1'b0, 2'b00, 1'b1);
        expect_res("post_rst", 8'h0E, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b0);
        check("end.ov", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
